// File: rtl/pll_fb_divider_if.sv
`default_nettype none
// ============================================================================
//  Module      : pll_fb_divider_if
//  Description : Control/status bundle of the PLL feedback divider.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pll_fb_divider_if #(
    parameter int DIV_W = 8
);
    logic             enable;
    logic [DIV_W-1:0] ndiv;
    logic             ndiv_load;
    logic             ndiv_ack;
    logic             fbclk;
    logic             wrap;
    logic [DIV_W-1:0] ndiv_active;

    modport master (
        output enable, ndiv, ndiv_load,
        input  ndiv_ack, fbclk, wrap, ndiv_active
    );

    modport slave (
        input  enable, ndiv, ndiv_load,
        output ndiv_ack, fbclk, wrap, ndiv_active
    );
endinterface
`default_nettype wire

// File: rtl/pll_fb_divider.sv
`default_nettype none
// ============================================================================
//  Module      : pll_fb_divider
//  Description : Programmable integer feedback divider; ratio changes via
//                req/ack and take effect only at a period boundary.
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_fb_divider #(
    parameter int DIV_W     = 8,
    parameter int DEFAULT_N = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    pll_fb_divider_if.slave   bus
);
    localparam logic [DIV_W-1:0] c_default_n = DIV_W'(DEFAULT_N);
    localparam logic [DIV_W-1:0] c_one       = DIV_W'(1);
    localparam logic [DIV_W-1:0] c_min_n     = DIV_W'(2);
    localparam logic [DIV_W:0]   c_one_w     = (DIV_W+1)'(1);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_nact;
    logic [DIV_W-1:0] r_shadow;
    logic             r_pending;
    logic             r_fbclk;
    logic             r_wrap;
    logic             r_ack;

    logic [DIV_W-1:0] w_cnt_next;
    logic [DIV_W-1:0] w_nact_next;
    logic [DIV_W-1:0] w_shadow_next;
    logic             w_pending_next;
    logic             w_fbclk_next;
    logic             w_wrap_next;
    logic             w_ack_next;
    logic             w_at_wrap;
    logic [DIV_W:0]   w_hi;

    always_comb begin
        w_cnt_next     = r_cnt;
        w_nact_next    = r_nact;
        w_shadow_next  = r_shadow;
        w_pending_next = r_pending;
        w_fbclk_next   = r_fbclk;
        w_wrap_next    = 1'b0;
        w_ack_next     = 1'b0;
        w_at_wrap      = (r_cnt == (r_nact - c_one));

        if (bus.enable) begin
            if (w_at_wrap) begin
                w_cnt_next  = '0;
                w_wrap_next = 1'b1;
                if (r_pending) begin
                    w_nact_next    = r_shadow;
                    w_pending_next = 1'b0;
                    w_ack_next     = 1'b1;
                end
            end else begin
                w_cnt_next = r_cnt + c_one;
            end
        end

        // Capture looks at the pending flag before this edge, so a load that
        // lands on the applying wrap is dropped and one on a plain wrap waits.
        if (bus.ndiv_load && !r_pending) begin
            w_shadow_next  = (bus.ndiv < c_min_n) ? c_min_n : bus.ndiv;
            w_pending_next = 1'b1;
        end

        // Extra bit keeps Nact+1 from overflowing at the maximum ratio.
        w_hi = ({1'b0, w_nact_next} + c_one_w) >> 1;
        if (bus.enable) begin
            w_fbclk_next = ({1'b0, w_cnt_next} < w_hi);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= c_default_n - c_one;
            r_nact    <= c_default_n;
            r_shadow  <= '0;
            r_pending <= 1'b0;
            r_fbclk   <= 1'b0;
            r_wrap    <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_nact    <= w_nact_next;
            r_shadow  <= w_shadow_next;
            r_pending <= w_pending_next;
            r_fbclk   <= w_fbclk_next;
            r_wrap    <= w_wrap_next;
            r_ack     <= w_ack_next;
        end
    end

    assign bus.fbclk       = r_fbclk;
    assign bus.wrap        = r_wrap;
    assign bus.ndiv_ack    = r_ack;
    assign bus.ndiv_active = r_nact;
endmodule
`default_nettype wire

// File: tb/tb_pll_fb_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pll_fb_divider
//  Description : Scoreboard bench for pll_fb_divider against a period model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_fb_divider;
    localparam int DIV_W     = 8;
    localparam int DEFAULT_N = 8;

    typedef struct packed {
        logic             fb;
        logic             wrap;
        logic             ack;
        logic [DIV_W-1:0] n;
    } exp_t;

    logic clk;
    logic rst;
    pll_fb_divider_if #(.DIV_W(DIV_W)) bus ();

    pll_fb_divider #(.DIV_W(DIV_W), .DEFAULT_N(DEFAULT_N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q[$];

    // Reference model: position within the current period and its length.
    int   m_pos, m_n, m_shadow;
    bit   m_pend, m_fb, m_wrap, m_ack;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = DEFAULT_N - 1; m_n = DEFAULT_N; m_shadow = 0;
        m_pend = 0; m_fb = 0; m_wrap = 0; m_ack = 0;
    endtask

    task automatic model_edge(input bit en, input bit ld, input int nd);
        bit old_pend = m_pend;
        m_wrap = 0;
        m_ack  = 0;
        if (en) begin
            if (m_pos == m_n - 1) begin
                m_pos  = 0;
                m_wrap = 1;
                if (m_pend) begin
                    m_n = m_shadow; m_pend = 0; m_ack = 1;
                end
            end else begin
                m_pos = m_pos + 1;
            end
            // High for the first ceil(N/2) cycles of each period.
            m_fb = (2 * m_pos < m_n);
        end
        if (ld && !old_pend) begin
            m_shadow = (nd < 2) ? 2 : nd;
            m_pend   = 1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fb"},   32'(bus.fbclk),       0);
        check({tag, "_wrap"}, 32'(bus.wrap),        0);
        check({tag, "_ack"},  32'(bus.ndiv_ack),    0);
        check({tag, "_nact"}, 32'(bus.ndiv_active), DEFAULT_N);
    endtask

    task automatic step(input bit en, input bit ld, input int nd);
        exp_t e;
        bus.enable    = en;
        bus.ndiv_load = ld;
        bus.ndiv      = DIV_W'(nd);
        model_edge(en, ld, nd);
        q.push_back('{fb: m_fb, wrap: m_wrap, ack: m_ack, n: DIV_W'(m_n)});
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = q.pop_front();
            check("fbclk", 32'(bus.fbclk),       32'(e.fb));
            check("wrap",  32'(bus.wrap),        32'(e.wrap));
            check("ack",   32'(bus.ndiv_ack),    32'(e.ack));
            check("nact",  32'(bus.ndiv_active), 32'(e.n));
        end
        bus.ndiv_load = 1'b0;
    endtask

    task automatic run(input int cycles, input bit en);
        for (int i = 0; i < cycles; i++) step(en, 0, 0);
    endtask

    task automatic load_and_wait(input int nd);
        bit seen = 0;
        step(1, 1, nd);
        for (int i = 0; i < 600 && !seen; i++) begin
            step(1, 0, 0);
            seen = bus.ndiv_ack;
        end
        if (!seen) check("ack_timeout", 0, 1);
    endtask

    task automatic run_to_pos(input int pos);
        for (int i = 0; i < 600 && m_pos != pos; i++) step(1, 0, 0);
        check("pos_reach", 32'(m_pos), 32'(pos));
    endtask

    initial begin
        rst = 1'b1;
        bus.enable = 1'b0; bus.ndiv_load = 1'b0; bus.ndiv = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst_init");
        rst = 1'b0;

        // Default ratio: rising FBclk with Wrap one CLK after enable.
        run(24, 1);

        // Ratio 5: 3 high / 2 low.
        load_and_wait(5);
        run(15, 1);
        check("nact_5", 32'(bus.ndiv_active), 5);

        // Back to 8, then load 12 at cnt=3; a second request at cnt=5 is ignored.
        load_and_wait(8);
        run_to_pos(3);
        step(1, 1, 12);
        run_to_pos(5);
        step(1, 1, 6);
        check("nact_still_8", 32'(bus.ndiv_active), 8);
        load_and_wait(12);
        run(40, 1);
        check("nact_12", 32'(bus.ndiv_active), 12);

        // Clamp of ratios below two.
        load_and_wait(0);
        check("nact_clamp0", 32'(bus.ndiv_active), 2);
        load_and_wait(1);
        check("nact_clamp1", 32'(bus.ndiv_active), 2);
        run(8, 1);

        // Enable freeze at cnt=2 with N=8.
        load_and_wait(8);
        run_to_pos(2);
        run(10, 0);
        run(20, 1);

        // Async reset mid-period with a pending load.
        load_and_wait(2);
        run_to_pos(1);
        step(1, 1, 10);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        rst = 1'b0;
        model_reset();
        run(30, 1);
        check("nact_after_rst", 32'(bus.ndiv_active), DEFAULT_N);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
